// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a valid/ready word FIFO.
// Frame: start, DATA_W data bits (MSB- or LSB-first), optional parity, 1-2 stop bits.
// Optional feature: define UART_TX_BREAK_EN to add the tx_break input (line break).
module uart_tx_fifo #(
  parameter int DATA_W      = 8,
  parameter int CLK_DIV     = 434,
  parameter int FIFO_DEPTH  = 16,
  parameter int MSB_FIRST   = 1,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                              clk_sys,
  input  logic                              rst_n,
  input  logic [DATA_W-1:0]                 tx_data,
  input  logic                              tx_vld,
`ifdef UART_TX_BREAK_EN
  input  logic                              tx_break,
`endif
  output logic                              tx_rdy,
  output logic                              uart_tx,
  output logic                              tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt,
  output logic                              ovf
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int IDX_W  = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_fifo: DATA_W must be in 5..9");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_fifo: CLK_DIV must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_msb
    $error("uart_tx_fifo: MSB_FIRST must be 0 or 1");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK, S_MAB
`endif
  } state_e;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q, ovf_q, busy_q;
  logic              push, pop;
  logic [DATA_W-1:0] head;

  state_e            state_q, state_d;
  logic              uart_q, uart_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;

  assign push     = tx_vld & rdy_q;
  assign head     = mem_q[rd_ptr_q];
  assign tx_rdy   = rdy_q;
  assign uart_tx  = uart_q;
  assign tx_busy  = busy_q;
  assign fifo_cnt = cnt_q;
  assign ovf      = ovf_q;

  // Data bit i of the frame, honouring the configured bit order.
  function automatic logic sel_bit(input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] j;
    j = (MSB_FIRST != 0) ? (IDX_W'(DATA_W - 1) - i) : i;
    return w[j];
  endfunction

  // FIFO occupancy next value; a refused push when full never reaches here since rdy_q is low.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage; no reset needed, contents are only read behind a valid count.
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // FIFO pointers, occupancy, ready and sticky overflow flag.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != CNT_W'(FIFO_DEPTH));
      ovf_q <= ovf_q | (tx_vld & ~rdy_q);
    end
  end

  // Frame FSM next state; a pop from IDLE or the end of STOP loads the next start bit.
  always_comb begin
    state_d = state_q;
    uart_d  = uart_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    data_d  = data_q;
    par_d   = par_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        uart_d = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          state_d = S_BREAK;
          uart_d  = 1'b0;
        end else
`endif
        if (cnt_q != '0) pop = 1'b1;
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        uart_d = 1'b0;
        if (!tx_break) begin
          state_d = S_MAB;
          uart_d  = 1'b1;
          baud_d  = BAUD_RELOAD;
        end
      end
`endif
      default: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          baud_d = BAUD_RELOAD;
          case (state_q)
            S_START: begin
              state_d = S_DATA;
              idx_d   = '0;
              uart_d  = sel_bit(data_q, '0);
            end
            S_DATA: begin
              if (idx_q == IDX_W'(DATA_W - 1)) begin
                if (PARITY_MODE != 0) begin
                  state_d = S_PARITY;
                  uart_d  = par_q;
                end else begin
                  state_d = S_STOP;
                  uart_d  = 1'b1;
                  stop_d  = 1'b0;
                end
              end else begin
                idx_d  = idx_q + 1'b1;
                uart_d = sel_bit(data_q, idx_q + 1'b1);
              end
            end
            S_PARITY: begin
              state_d = S_STOP;
              uart_d  = 1'b1;
              stop_d  = 1'b0;
            end
            S_STOP: begin
              uart_d = 1'b1;
              if (stop_q != 1'(STOP_BITS - 1)) begin
                stop_d = 1'b1;
              end else begin
`ifdef UART_TX_BREAK_EN
                if (tx_break) begin
                  state_d = S_BREAK;
                  uart_d  = 1'b0;
                end else
`endif
                if (cnt_q != '0) pop = 1'b1;
                else             state_d = S_IDLE;
              end
            end
            default: begin
              state_d = S_IDLE;
              uart_d  = 1'b1;
            end
          endcase
        end
      end
    endcase
    if (pop) begin
      state_d = S_START;
      uart_d  = 1'b0;
      baud_d  = BAUD_RELOAD;
      data_d  = head;
      par_d   = (PARITY_MODE == 2) ? ~(^head) : (^head);
    end
  end

  // Frame FSM registers, registered line output and busy flag.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      uart_q  <= 1'b1;
      baud_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      par_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      uart_q  <= uart_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      par_q   <= par_d;
      busy_q  <= (state_q != S_IDLE) | (cnt_q != '0);
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Synthesizable, parametrised UART transmitter with an input FIFO. It replaces the bench-only serial driver as the board-level debug/control TX path. Frame format is fully parametrised: data width, bit order, parity mode, stop bits and baud divider. The default frame is start, 8 data bits MSB-first, XOR (even) parity, 1 stop. It sits between the register/command logic (valid/ready word interface) and the uart_tx pad.

Parameters:
DATA_W, 8, data bits per frame (5..9)
CLK_DIV, 434, clk_sys cycles per bit (>=2); 434 = 115200 baud at 50 MHz
FIFO_DEPTH, 16, FIFO entries; power of 2, >=2
MSB_FIRST, 1, 1 = data sent MSB first, 0 = LSB first
PARITY_MODE, 1, 0 = none, 1 = even (XOR of data), 2 = odd (inverted XOR)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk_sys  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_W  word to transmit
tx_vld  input  1  tx_data valid
tx_rdy  output  1  FIFO can accept; word accepted on tx_vld & tx_rdy at the clk_sys rising edge
uart_tx  output  1  serial line, registered, idle high
tx_busy  output  1  frame in progress or FIFO non-empty
fifo_cnt  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy
ovf  output  1  sticky: tx_vld seen while tx_rdy low; cleared only by reset

Behaviour:
- Reset (async, rst_n low): uart_tx=1, tx_rdy=0 while rst_n low and 1 from the first edge after release, tx_busy=0, fifo_cnt=0, ovf=0. FIFO is flushed, FSM goes to IDLE and the baud counter clears. Reset mid-frame aborts the frame immediately and the line returns high with no stop bit.
- tx_rdy = (fifo_cnt != FIFO_DEPTH). When full, a push is refused even if a pop occurs in the same cycle. Simultaneous push and pop when not full leaves fifo_cnt unchanged. FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: uart_tx=1. If FIFO non-empty: pop the head into the shift register, compute parity, load baud_cnt=CLK_DIV-1, drive uart_tx=0, go to START.
- Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE drives uart_tx low from edge N+1.
- Each bit holds exactly CLK_DIV cycles. baud_cnt counts down; the bit advances on the cycle baud_cnt==0.
- START -> DATA with bit_idx=0. DATA sends tx_data[DATA_W-1-bit_idx] if MSB_FIRST=1, else tx_data[bit_idx]. After DATA_W bits it goes to PARITY if PARITY_MODE!=0, else to STOP.
- PARITY: drives ^data for mode 1 and ~^data for mode 2, then goes to STOP.
- STOP: uart_tx=1 for STOP_BITS*CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and drive the next start bit on the same edge (no idle gap); otherwise go to IDLE.
- Frame length: (1 + DATA_W + (PARITY_MODE!=0) + STOP_BITS) * CLK_DIV cycles.
- tx_busy = (state != IDLE) | (fifo_cnt != 0), registered.
- ovf sets on the edge where tx_vld=1 and tx_rdy=0.
- Illegal parameter values are rejected with an elaboration-time $error.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: adds input tx_break (1 bit). While tx_break=1, uart_tx is forced low from the next edge. The FSM holds in IDLE, or finishes the current frame before entering break. The FIFO keeps accepting words. When tx_break drops, the line goes high for at least CLK_DIV cycles (mark-after-break) before the next start bit.
- Not defined: no tx_break port and no break logic; behaviour is exactly as above.

Test Plan:
- Default params except CLK_DIV=4. Push 0x01 -> uart_tx pattern per 4-cycle bit: 0,0,0,0,0,0,0,0,1,1(parity),1(stop). Start bit begins 1 cycle after accept; 44-cycle frame.
- Push 0x00, 0x85, 0xAA back-to-back -> parity bits 0, 1, 0. No idle cycle between frames; tx_busy falls 1 cycle after the last stop bit ends; fifo_cnt goes 3->2->1->0.
- MSB_FIRST=0, PARITY_MODE=2, STOP_BITS=2, DATA_W=7: push 0x41 -> data bits 1,0,0,0,0,0,1; parity 1 (odd); 8 stop cycles; 44-cycle frame.
- FIFO_DEPTH=4, hold tx_vld for 6 words during the first frame -> tx_rdy=0 once 4 are queued, ovf=1 and sticky, exactly 5 frames transmitted (1 in flight + 4 queued).
- Assert rst_n low in the middle of DATA of 0xAA -> uart_tx=1 asynchronously; after release fifo_cnt=0, tx_busy=0, no further frames sent.
- UART_TX_BREAK_EN: tx_break high for 100 cycles with 2 words queued -> line low for 100 cycles, then >=CLK_DIV high, then both frames sent intact.
